// File: rtl/mips_dcache.sv
// mips_dcache: direct-mapped, one-word-line, write-back/write-allocate data cache
// with a fixed-latency memory port and saturating hit/miss counters.
module mips_dcache #(
  parameter int LINES   = 8,
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_be,
  input  logic             inv,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int IDX = $clog2(LINES);
  localparam int TW  = 30 - IDX;
  localparam int CW  = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TW-1:0]    tag_q [LINES];
  logic [31:0]      data_q [LINES];
  logic [31:2]      addr_q;
  logic [31:0]      wdata_q, rdata_q, wd, base, merged;
  logic [3:0]       be_q, be;
  logic             write_q, store, idle, accept, hit, last, line_we;
  logic [31:2]      a;
  logic [IDX-1:0]   idx;
  logic [TW-1:0]    tag;
  logic [CNT_W-1:0] hit_q, miss_q;
  logic             unused_addr;
  assign unused_addr = ^req_addr[1:0];
  // In IDLE the live request is decoded so hits complete without a latch stage.
  assign idle   = state_q == IDLE;
  assign a      = idle ? req_addr[31:2] : addr_q;
  assign wd     = idle ? req_wdata : wdata_q;
  assign be     = idle ? req_be : be_q;
  assign store  = idle ? req_write : write_q;
  assign idx    = a[IDX+1:2];
  assign tag    = a[31:IDX+2];
  assign hit    = valid_q[idx] && tag_q[idx] == tag;
  assign accept = rst_b && idle && req_valid && !inv;
  assign last   = cnt_q == '0;
  assign base   = state_q == FILL ? mem_rdata : data_q[idx];
  assign req_ready  = accept;
  assign resp_valid = state_q == RESPOND;
  assign resp_rdata = rdata_q;
  assign hit_cnt    = hit_q;
  assign miss_cnt   = miss_q;
  always_comb begin
    merged = base;
    for (int i = 0; i < 4; i++) if (store && be[i]) merged[8*i +: 8] = wd[8*i +: 8];
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = last ? cnt_q : cnt_q - 1'b1;
    line_we   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = hit ? RESPOND : (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
        cnt_d   = CW'(MEM_LAT - 1);
        line_we = hit && store;
      end
      WRITEBACK: begin
        mem_addr  = {tag_q[idx], idx, 2'b00};
        mem_wdata = data_q[idx];
        mem_we    = last;
        state_d   = last ? FILL : WRITEBACK;
        cnt_d     = last ? CW'(MEM_LAT - 1) : cnt_d;
      end
      FILL: begin
        mem_addr = {tag, idx, 2'b00};
        line_we  = last;
        state_d  = last ? RESPOND : FILL;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && inv) begin
        valid_q <= '0;
        dirty_q <= '0;
      end else if (line_we) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= store;
      end
      if (accept) begin
        addr_q  <= req_addr[31:2];
        wdata_q <= req_wdata;
        be_q    <= req_be;
        write_q <= req_write;
        hit_q   <= hit_q + CNT_W'(hit && hit_q != '1);
        miss_q  <= miss_q + CNT_W'(!hit && miss_q != '1);
      end
      if (!store && ((accept && hit) || (state_q == FILL && last))) rdata_q <= base;
    end
  end
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= merged;
    end
  end
endmodule

// File: tb/tb_mips_dcache.sv
// tb_mips_dcache: directed and random transactions against a flat-memory model of
// the cache plus a per-index line-residency model for hit/miss timing.
module tb_mips_dcache;
  localparam int L = 4;
  localparam int CW = 8;
  logic clk = 0, rst_b = 0, req_valid = 0, req_write = 0, inv = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic [3:0] req_be = 0;
  logic req_ready, resp_valid, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [CW-1:0] hit_cnt, miss_cnt;
  int vectors = 0, miscompares = 0;
  bit mv[8], md[8];
  logic [31:0] mla[8];
  logic [31:0] ext_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int mh = 0, mm = 0;

  mips_dcache #(.LINES(8), .MEM_LAT(L), .CNT_W(CW)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .inv(inv),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) if (rst_b && mem_we) ext_mem[mem_addr] = mem_wdata;

  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  function automatic logic [31:0] ext_rd(logic [31:0] a);
    return ext_mem.exists(a) ? ext_mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Dirty data that is dropped without writeback reverts to what memory holds.
  task automatic drop_lines();
    for (int i = 0; i < 8; i++) begin
      if (mv[i] && md[i]) ref_mem[mla[i]] = ext_rd(mla[i]);
      mv[i] = 0;
      md[i] = 0;
    end
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input bit noise);
    int idx, lat, we_n, wb_c, exp_lat;
    bit hit, dm;
    logic [31:0] la, va, vd, wb_a, wb_d, fa;
    la = {a[31:2], 2'b00};
    idx = int'(a[4:2]);
    hit = mv[idx] && mla[idx] == la;
    dm = !hit && mv[idx] && md[idx];
    va = mla[idx];
    vd = ref_rd(va);
    exp_lat = hit ? 1 : dm ? 2 * L + 1 : L + 1;
    lat = 0; we_n = 0; wb_c = 0; wb_a = 0; wb_d = 0; fa = 0;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
    mem_rdata = ext_rd(la);
    #1;
    chk("ready", req_ready, 1);
    chk("idle_mem_addr", mem_addr, 0);
    @(posedge clk);
    #1;
    req_valid = 0; req_write = $urandom; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    inv = noise && ($urandom_range(0, 1) == 1);
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_we) begin we_n++; wb_a = mem_addr; wb_d = mem_wdata; wb_c = c; end
      if (c == 1 && !hit) fa = mem_addr;
      if (resp_valid) lat = c;
    end
    inv = 0;
    chk("latency", lat, exp_lat);
    chk("we_pulses", we_n, dm ? 1 : 0);
    if (dm) begin
      chk("wb_addr", wb_a, va);
      chk("wb_data", wb_d, vd);
      chk("wb_cycle", wb_c, L);
    end
    if (!hit) chk("mem_addr", fa, dm ? va : la);
    if (w) ref_mem[la] = merge(ref_rd(la), wd, be);
    else chk("rdata", resp_rdata, ref_rd(la));
    md[idx] = hit ? (md[idx] | w) : w;
    mv[idx] = 1;
    mla[idx] = la;
    if (hit) mh = mh == 255 ? 255 : mh + 1;
    else mm = mm == 255 ? 255 : mm + 1;
    chk("hit_cnt", hit_cnt, mh);
    chk("miss_cnt", miss_cnt, mm);
    chk("resp_mem_addr", mem_addr, 0);
  endtask

  task automatic inv_pulse(input logic [31:0] a);
    @(negedge clk);
    inv = 1; req_valid = 1; req_write = 0; req_addr = a;
    #1 chk("inv_ready", req_ready, 0);
    @(posedge clk);
    #1 inv = 0; req_valid = 0;
    drop_lines();
  endtask

  task automatic reset_mid_fill(input logic [31:0] a);
    int bad;
    bad = 0;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = a; mem_rdata = ext_rd(a);
    @(posedge clk);
    #1 req_valid = 0;
    repeat (2) @(negedge clk);
    rst_b = 0; req_valid = 1;
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    @(negedge clk);
    rst_b = 1; req_valid = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp_valid || mem_we) bad++;
    end
    chk("abort_quiet", bad, 0);
    drop_lines();
    mh = 0; mm = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; mla[i] = 0; end
    req_valid = 1;
    #1;
    chk("reset_ready", req_ready, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_rdata", resp_rdata, 0);
    chk("reset_hit", hit_cnt, 0);
    chk("reset_miss", miss_cnt, 0);
    req_valid = 0;
    repeat (2) @(negedge clk);
    rst_b = 1;
    ext_mem[32'h40] = 32'hDEADBEEF;
    ref_mem[32'h40] = 32'hDEADBEEF;
    txn(0, 32'h40, 0, 0, 0);
    chk("cold_load", resp_rdata, 32'hDEADBEEF);
    txn(1, 32'h40, 32'h000000AA, 4'b0001, 0);
    txn(0, 32'h40, 0, 0, 0);
    chk("merged_load", resp_rdata, 32'hDEADBEAA);
    chk("two_hits", hit_cnt, 2);
    txn(0, 32'h60, 0, 0, 0);
    chk("wb_landed", ext_rd(32'h40), 32'hDEADBEAA);
    inv_pulse(32'h60);
    txn(0, 32'h60, 0, 0, 0);
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 15) == 0) inv_pulse($urandom);
      txn(1'($urandom), {25'($urandom), 5'($urandom), 2'($urandom)}, $urandom, 4'($urandom), 1);
    end
    inv_pulse(0);
    reset_mid_fill(32'h100);
    txn(0, 32'h100, 0, 0, 0);
    for (int n = 0; n < 260; n++) txn(0, 32'h100, 0, 0, 0);
    chk("hit_saturated", hit_cnt, 8'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips_dcache.md
MIPS_DCACHE -- requirements
Module: mips_dcache

Interface
REQ-001 Parameter LINES, default 8, meaning number of direct-mapped one-word lines; SHALL be a power of 2, minimum 2.
REQ-002 Parameter MEM_LAT, default 4, meaning fixed memory access latency in cycles; SHALL be at least 1.
REQ-003 Parameter CNT_W, default 16, meaning width of the hit and miss counters.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_b  in  1  reset, asynchronous and active-low.
REQ-006 req_valid  in  1  core request present.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address; bits [1:0] ignored.
REQ-009 req_wdata  in  32  store data.
REQ-010 req_be  in  4  byte enables for a store; bit i covers bits [8i+7:8i].
REQ-011 inv  in  1  pulse that invalidates all lines without writeback.
REQ-012 req_ready  out  1  high when a request is accepted this cycle.
REQ-013 resp_valid  out  1  one-cycle pulse marking completion of a request.
REQ-014 resp_rdata  out  32  load data, valid while resp_valid is high.
REQ-015 mem_addr  out  32  word-aligned memory address.
REQ-016 mem_wdata  out  32  writeback data.
REQ-017 mem_we  out  1  memory write strobe.
REQ-018 mem_rdata  in  32  memory read data, sampled on the last fill cycle.
REQ-019 hit_cnt, miss_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-020 The cache SHALL decode each address as: index = addr[IDX+1:2] and tag = addr[31:IDX+2], where IDX = log2(LINES).
REQ-021 Each line SHALL hold valid, dirty, tag and 32-bit data.
REQ-022 The policy SHALL be write-back with write-allocate.
REQ-023 The FSM SHALL have four states: IDLE, WRITEBACK, FILL and RESPOND; req_ready SHALL be high only in IDLE with req_valid high and inv low.
REQ-024 At acceptance, the cache SHALL latch the address, write flag, data and byte enables; later changes on the req_* inputs SHALL have no effect.
REQ-025 Hit (valid and tag equal), IDLE -> RESPOND:
  - load: resp_rdata = line data;
  - store: merge the enabled bytes into the line and set dirty;
  - hit_cnt += 1.
REQ-026 Miss on a clean or invalid line: IDLE -> FILL and miss_cnt += 1.
REQ-027 Miss on a valid dirty line: IDLE -> WRITEBACK and miss_cnt += 1.
REQ-028 WRITEBACK SHALL last MEM_LAT cycles, driving:
  - mem_addr = {victim tag, index, 2'b00} and mem_wdata = victim data;
  - mem_we high on the final cycle only;
  - then -> FILL.
REQ-029 FILL SHALL last MEM_LAT cycles, driving mem_addr = {req tag, index, 2'b00} with mem_we low.
  - On the final cycle it SHALL capture mem_rdata into the line and set valid=1, dirty=0 and the tag.
  - It SHALL apply a pending store merge in the same write, setting dirty=1.
  - Then -> RESPOND.
REQ-030 RESPOND SHALL last one cycle with resp_valid=1, then -> IDLE.
REQ-031 Latency from the acceptance edge to resp_valid: hit 1 cycle; clean miss MEM_LAT+1; dirty miss 2*MEM_LAT+1.
REQ-032 A single down-counter of ceil(log2(MEM_LAT+1)) bits SHALL time WRITEBACK and FILL.
  - It SHALL reload to MEM_LAT-1 on every state entry.
  - It SHALL never wrap below 0.
REQ-033 inv SHALL clear all valid and dirty bits in one cycle when sampled in IDLE, and SHALL have priority over a simultaneous req_valid (no accept that cycle).
REQ-034 inv outside IDLE SHALL be ignored.
REQ-035 hit_cnt and miss_cnt SHALL saturate at all ones and never wrap.
REQ-036 mem_addr and mem_wdata SHALL be 0 in IDLE and RESPOND.
REQ-037 mem_we SHALL never be high outside the final WRITEBACK cycle.
REQ-038 resp_rdata SHALL hold its last value when resp_valid is low.

Reset
REQ-039 With rst_b low, the following SHALL take effect immediately, independent of clk:
  - state = IDLE;
  - all valid and dirty bits = 0;
  - req_ready, resp_valid and mem_we = 0;
  - mem_addr, mem_wdata and resp_rdata = 0;
  - hit_cnt and miss_cnt = 0.
REQ-040 Reset asserted during WRITEBACK or FILL SHALL abort the operation.
  - No mem_we pulse SHALL follow.
  - The aborted request SHALL never produce resp_valid.
REQ-041 Tag and data arrays need not reset; only the valid bits qualify them.

Verification (LINES=8, MEM_LAT=4)
REQ-042 Cold load of 0x40 with mem_rdata=0xDEADBEEF -> FILL for 4 cycles with mem_addr=0x40, then resp_valid on cycle 5 with resp_rdata=0xDEADBEEF, miss_cnt=1.
REQ-043 Store to 0x40 with req_wdata=0x000000AA and req_be=4'b0001, then load 0x40 -> both hits; the load returns 0xDEADBEAA; hit_cnt=2.
REQ-044 Load 0x60 (same index, dirty victim) -> mem_we pulses once on cycle 4 with mem_addr=0x40 and mem_wdata=0xDEADBEAA; FILL of 0x60 follows; resp_valid on cycle 9.
REQ-045 inv together with req_valid in IDLE -> req_ready=0 and all lines invalid; the next load of 0x60 misses.
REQ-046 rst_b low for 1 cycle mid-FILL -> resp_valid stays 0, mem_we stays 0, and counters read 0.
REQ-047 Run 2^16+5 hits with CNT_W=16 -> hit_cnt holds 0xFFFF.
